io_port_bridge: RTL and testbench
=================================

Name: io_port_bridge

Overview:
- External-device side of the processor's 16-bit inputPort/outputPort pair.
- Captures words the processor emits on OUT instructions into an output FIFO and drains them to an external consumer over valid/ready.
- Accepts words from an external producer over valid/ready into an input FIFO, presents the head to the processor's inputPort, and pops it when an IN instruction consumes it.
- Flags stall conditions so the pipeline can hold on empty-input or full-output.

Parameters:
WIDTH, 16, data width of both directions
DEPTH, 4, entries per FIFO; power of two, >= 2
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all state immediately on assertion
proc_out_data  in  WIDTH  processor outputPort value
proc_out_we  in  1  OUT-instruction write-back strobe, one cycle per word
proc_in_data  out  WIDTH  drives processor inputPort
proc_in_re  in  1  IN-instruction consume strobe, one cycle per word
proc_stall  out  1  pipeline hold request
ext_in_data  in  WIDTH  external producer data
ext_in_valid  in  1  producer has data
ext_in_ready  out  1  bridge can accept
ext_out_data  out  WIDTH  external consumer data
ext_out_valid  out  1  bridge has data
ext_out_ready  in  1  consumer accepts
in_count  out  CW  input FIFO occupancy
out_count  out  CW  output FIFO occupancy

Behaviour:
- Reset (reset low, async): pointers and counts = 0; ext_in_ready=0 while reset low, 1 from first edge after release; ext_out_valid=0; ext_out_data=0; proc_in_data=0; proc_stall=0. Storage contents need not clear.
- Both FIFOs: circular buffers, read/write pointers wrap modulo DEPTH, full = (count==DEPTH), empty = (count==0); full/empty derived from registered count only.
- Input FIFO push: ext_in_valid && ext_in_ready. ext_in_ready = !in_full (registered count).
- Input FIFO pop: proc_in_re && !in_empty. proc_in_data = head entry (combinational from storage); 0 when empty.
- Output FIFO push: proc_out_we && !out_full; when full the word is dropped (never overwrites).
- Output FIFO pop: ext_out_valid && ext_out_ready. ext_out_valid = !out_empty; ext_out_data = head entry, held stable while valid && !ready.
- Simultaneous push+pop, neither full nor empty: both occur, count unchanged.
- Push while full with same-cycle pop: push refused, pop occurs (no pass-through).
- Pop while empty with same-cycle push: pop ignored, push occurs; a pushed word becomes visible at the head the cycle after the push (latency 1, no bypass).
- proc_stall = (proc_in_re && in_empty) || (proc_out_we && out_full); combinational, same cycle. An ignored proc_in_re causes no pointer movement.
- Reset asserted mid-transfer: all in-flight words are discarded; no partial handshake completes on that edge.

Optional Feature:
IO_PORT_ERR_FLAGS_EN
- Defined: adds outputs out_overflow (1) and in_underflow (1), both sticky.
  - out_overflow sets on proc_out_we while out_full.
  - in_underflow sets on proc_in_re while in_empty.
  - Both clear only on reset; 0 after reset.
- Undefined: ports absent; behaviour otherwise identical.

Test Plan:
- Reset then idle -> ext_in_ready=1, ext_out_valid=0, proc_in_data=0x0000, counts 0, proc_stall=0.
- Producer pushes 0x1111, 0x2222, 0x3333 back-to-back; proc_in_re pulsed 3 times afterwards -> proc_in_data shows 0x1111, 0x2222, 0x3333 in order; in_count 3->0.
- proc_out_we with 0xA5A5..0xA5A8 (4 words), ext_out_ready=0 -> out_count=4; a fifth write 0xBEEF gives proc_stall=1, word dropped (out_overflow=1 if enabled). Then ready=1 -> A5A5..A5A8 drained, no BEEF.
- Input FIFO empty, proc_in_re=1 -> proc_stall=1, in_count stays 0; same cycle ext push 0x0042 -> next cycle proc_in_data=0x0042, proc_stall=0.
- Output FIFO holding 2 words, proc_out_we and ext pop in same cycle for 6 cycles -> out_count stays 2, order preserved across pointer wrap.
- Fill input FIFO to 3, assert reset low mid-cycle -> counts 0 immediately, ext_out_valid=0; after release the first pushed word 0x7777 appears at head.

Source files
------------

// File: rtl/io_port_bridge.sv
// Bridge between the processor's inputPort/outputPort and two external valid/ready streams.
// Optional sticky error flags (out_overflow, in_underflow) are built when IO_PORT_ERR_FLAGS_EN is defined.
module io_port_bridge #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] proc_out_data,
    input  logic             proc_out_we,
    output logic [WIDTH-1:0] proc_in_data,
    input  logic             proc_in_re,
    output logic             proc_stall,
    input  logic [WIDTH-1:0] ext_in_data,
    input  logic             ext_in_valid,
    output logic             ext_in_ready,
    output logic [WIDTH-1:0] ext_out_data,
    output logic             ext_out_valid,
    input  logic             ext_out_ready,
    output logic [CW-1:0]    in_count,
    output logic [CW-1:0]    out_count
`ifdef IO_PORT_ERR_FLAGS_EN
    ,
    output logic             out_overflow,
    output logic             in_underflow
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] in_mem  [DEPTH];
    logic [WIDTH-1:0] out_mem [DEPTH];

    logic [PW-1:0] in_wr_ptr_reg, in_rd_ptr_reg;
    logic [PW-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
    logic [CW-1:0] in_count_reg, in_count_next;
    logic [CW-1:0] out_count_reg, out_count_next;
    logic          ready_en_reg;

    logic in_full, in_empty, out_full, out_empty;
    logic in_push, in_pop, out_push, out_pop;

    assign in_full   = (in_count_reg == CW'(DEPTH));
    assign in_empty  = (in_count_reg == '0);
    assign out_full  = (out_count_reg == CW'(DEPTH));
    assign out_empty = (out_count_reg == '0);

    // ready_en_reg keeps the producer side closed until the first edge after reset release
    assign ext_in_ready  = ready_en_reg && !in_full;
    assign ext_out_valid = !out_empty;

    assign in_push  = ext_in_valid && ext_in_ready;
    assign in_pop   = proc_in_re && !in_empty;
    assign out_push = proc_out_we && !out_full;
    assign out_pop  = ext_out_valid && ext_out_ready;

    assign proc_in_data = in_empty  ? '0 : in_mem[in_rd_ptr_reg];
    assign ext_out_data = out_empty ? '0 : out_mem[out_rd_ptr_reg];
    assign proc_stall   = (proc_in_re && in_empty) || (proc_out_we && out_full);

    assign in_count  = in_count_reg;
    assign out_count = out_count_reg;

    always_comb begin
        in_count_next = in_count_reg;
        case ({in_push, in_pop})
            2'b10:   in_count_next = in_count_reg + CW'(1);
            2'b01:   in_count_next = in_count_reg - CW'(1);
            default: in_count_next = in_count_reg;
        endcase
    end

    always_comb begin
        out_count_next = out_count_reg;
        case ({out_push, out_pop})
            2'b10:   out_count_next = out_count_reg + CW'(1);
            2'b01:   out_count_next = out_count_reg - CW'(1);
            default: out_count_next = out_count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_reg   <= 1'b0;
            in_wr_ptr_reg  <= '0;
            in_rd_ptr_reg  <= '0;
            in_count_reg   <= '0;
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_count_reg  <= '0;
        end else begin
            ready_en_reg  <= 1'b1;
            in_count_reg  <= in_count_next;
            out_count_reg <= out_count_next;
            if (in_push)  in_wr_ptr_reg  <= in_wr_ptr_reg + PW'(1);
            if (in_pop)   in_rd_ptr_reg  <= in_rd_ptr_reg + PW'(1);
            if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + PW'(1);
            if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + PW'(1);
        end
    end

    // Storage is not reset; a push never targets the head slot unless the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset && in_push)  in_mem[in_wr_ptr_reg]   <= ext_in_data;
        if (reset && out_push) out_mem[out_wr_ptr_reg] <= proc_out_data;
    end

`ifdef IO_PORT_ERR_FLAGS_EN
    logic out_overflow_reg, in_underflow_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_overflow_reg <= 1'b0;
            in_underflow_reg <= 1'b0;
        end else begin
            out_overflow_reg <= out_overflow_reg | (proc_out_we && out_full);
            in_underflow_reg <= in_underflow_reg | (proc_in_re && in_empty);
        end
    end

    assign out_overflow = out_overflow_reg;
    assign in_underflow = in_underflow_reg;
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: queue-based reference model, directed scenarios and random traffic.
module tb_io_port_bridge;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] proc_out_data = '0;
    logic             proc_out_we = 1'b0;
    logic [WIDTH-1:0] proc_in_data;
    logic             proc_in_re = 1'b0;
    logic             proc_stall;
    logic [WIDTH-1:0] ext_in_data = '0;
    logic             ext_in_valid = 1'b0;
    logic             ext_in_ready;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready = 1'b0;
    logic [CW-1:0]    in_count;
    logic [CW-1:0]    out_count;
`ifdef IO_PORT_ERR_FLAGS_EN
    logic             out_overflow;
    logic             in_underflow;
`endif

    always #5 clk = ~clk;

    io_port_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .proc_out_data(proc_out_data),
        .proc_out_we  (proc_out_we),
        .proc_in_data (proc_in_data),
        .proc_in_re   (proc_in_re),
        .proc_stall   (proc_stall),
        .ext_in_data  (ext_in_data),
        .ext_in_valid (ext_in_valid),
        .ext_in_ready (ext_in_ready),
        .ext_out_data (ext_out_data),
        .ext_out_valid(ext_out_valid),
        .ext_out_ready(ext_out_ready),
        .in_count     (in_count),
        .out_count    (out_count)
`ifdef IO_PORT_ERR_FLAGS_EN
        ,
        .out_overflow (out_overflow),
        .in_underflow (in_underflow)
`endif
    );

    // Reference model: two bounded queues plus the producer-enable and sticky error bits.
    logic [WIDTH-1:0] m_in[$];
    logic [WIDTH-1:0] m_out[$];
    bit m_en  = 0;
    bit m_ovf = 0;
    bit m_udf = 0;

    logic             exp_ready, exp_valid, exp_stall;
    logic [WIDTH-1:0] exp_in_data, exp_out_data;
    logic [CW-1:0]    exp_in_count, exp_out_count;

    int total = 0;
    int bad   = 0;

    task automatic model_clear();
        m_in.delete();
        m_out.delete();
        m_en  = 0;
        m_ovf = 0;
        m_udf = 0;
    endtask

    // Apply inputs, let them settle, and derive the expected outputs for this cycle.
    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic re,
                         input logic we, input logic [WIDTH-1:0] wd, input logic rdy);
        ext_in_valid  = v;
        ext_in_data   = d;
        proc_in_re    = re;
        proc_out_we   = we;
        proc_out_data = wd;
        ext_out_ready = rdy;
        #1;
        exp_ready     = m_en && (m_in.size() < DEPTH);
        exp_valid     = (m_out.size() > 0);
        exp_out_data  = (m_out.size() > 0) ? m_out[0] : '0;
        exp_in_data   = (m_in.size() > 0) ? m_in[0] : '0;
        exp_stall     = (re && m_in.size() == 0) || (we && m_out.size() == DEPTH);
        exp_in_count  = CW'(m_in.size());
        exp_out_count = CW'(m_out.size());
    endtask

    task automatic tick();
        bit ipush, ipop, opush, opop;
        @(posedge clk);
        if (reset) begin
            ipush = ext_in_valid && m_en && (m_in.size() < DEPTH);
            ipop  = proc_in_re && (m_in.size() > 0);
            opush = proc_out_we && (m_out.size() < DEPTH);
            opop  = ext_out_ready && (m_out.size() > 0);
            if (proc_out_we && m_out.size() == DEPTH) m_ovf = 1;
            if (proc_in_re && m_in.size() == 0) m_udf = 1;
            if (ipop)  void'(m_in.pop_front());
            if (ipush) m_in.push_back(ext_in_data);
            if (opop)  void'(m_out.pop_front());
            if (opush) m_out.push_back(proc_out_data);
            m_en = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        drive(0, '0, 0, 0, '0, 0);
        tick();
        tick();
        drive(0, '0, 0, 0, '0, 0);
        total++; if (ext_in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_low actual=%0h required=0", ext_in_ready); end
        total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid actual=%0h required=0", ext_out_valid); end
        total++; if (ext_out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data actual=%h required=0000", ext_out_data); end
        total++; if (proc_in_data !== 16'h0000) begin bad++; $display("FAIL rst_in_data actual=%h required=0000", proc_in_data); end
        total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL rst_stall actual=%0h required=0", proc_stall); end
        total++; if (in_count !== '0 || out_count !== '0) begin bad++; $display("FAIL rst_counts actual=%0d/%0d required=0/0", in_count, out_count); end
        reset = 1'b1;
        drive(0, '0, 0, 0, '0, 0);
        total++; if (ext_in_ready !== exp_ready) begin bad++; $display("FAIL rel_ready_pre actual=%0h required=%0h", ext_in_ready, exp_ready); end
        tick();
        drive(0, '0, 0, 0, '0, 0);
        total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL idle_ready actual=%0h required=1", ext_in_ready); end
        total++; if (ext_out_valid !== 1'b0 || proc_stall !== 1'b0) begin bad++; $display("FAIL idle_valid_stall actual=%0h/%0h required=0/0", ext_out_valid, proc_stall); end
        total++; if (proc_in_data !== 16'h0000) begin bad++; $display("FAIL idle_in_data actual=%h required=0000", proc_in_data); end
`ifdef IO_PORT_ERR_FLAGS_EN
        total++; if (out_overflow !== 1'b0 || in_underflow !== 1'b0) begin bad++; $display("FAIL rst_flags actual=%0h/%0h required=0/0", out_overflow, in_underflow); end
`endif
        $display("txn reset released");
    endtask

    task automatic test_in_fifo();
        logic [WIDTH-1:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};
        for (int i = 0; i < 3; i++) begin
            drive(1, words[i], 0, 0, '0, 0);
            total++; if (ext_in_ready !== exp_ready) begin bad++; $display("FAIL in_push_ready actual=%0h required=%0h", ext_in_ready, exp_ready); end
            tick();
            $display("txn ext push %h", words[i]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0, '0, 0);
            total++; if (in_count !== exp_in_count) begin bad++; $display("FAIL in_count actual=%0d required=%0d", in_count, exp_in_count); end
            total++; if (proc_in_data !== exp_in_data || exp_in_data !== words[i]) begin bad++; $display("FAIL in_head actual=%h required=%h", proc_in_data, words[i]); end
            total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL in_pop_stall actual=%0h required=0", proc_stall); end
            tick();
            $display("txn proc pop %h", exp_in_data);
        end
        drive(0, '0, 0, 0, '0, 0);
        total++; if (in_count !== '0) begin bad++; $display("FAIL in_drained actual=%0d required=0", in_count); end
    endtask

    task automatic test_out_overflow();
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 0, 1, 16'hA5A5 + 16'(i), 0);
            tick();
            $display("txn proc write %h", 16'hA5A5 + 16'(i));
        end
        drive(0, '0, 0, 0, '0, 0);
        total++; if (out_count !== CW'(4)) begin bad++; $display("FAIL out_full_count actual=%0d required=4", out_count); end
        drive(0, '0, 0, 1, 16'hBEEF, 0);
        total++; if (proc_stall !== exp_stall || exp_stall !== 1'b1) begin bad++; $display("FAIL out_full_stall actual=%0h required=1", proc_stall); end
        tick();
        $display("txn proc write BEEF while full");
`ifdef IO_PORT_ERR_FLAGS_EN
        total++; if (out_overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag actual=%0h required=1", out_overflow); end
`endif
        for (int i = 0; i < 5; i++) begin
            drive(0, '0, 0, 0, '0, 1);
            total++; if (ext_out_valid !== exp_valid) begin bad++; $display("FAIL drain_valid actual=%0h required=%0h", ext_out_valid, exp_valid); end
            total++; if (ext_out_data !== exp_out_data) begin bad++; $display("FAIL drain_data actual=%h required=%h", ext_out_data, exp_out_data); end
            tick();
            $display("txn ext drain step %0d data %h", i, exp_out_data);
        end
        drive(0, '0, 0, 0, '0, 0);
        total++; if (out_count !== '0) begin bad++; $display("FAIL drain_count actual=%0d required=0", out_count); end
    endtask

    task automatic test_empty_pop_push();
        drive(1, 16'h0042, 1, 0, '0, 0);
        total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL empty_re_stall actual=%0h required=1", proc_stall); end
        total++; if (in_count !== '0) begin bad++; $display("FAIL empty_re_count actual=%0d required=0", in_count); end
        tick();
        $display("txn pop on empty with push 0042");
`ifdef IO_PORT_ERR_FLAGS_EN
        total++; if (in_underflow !== 1'b1) begin bad++; $display("FAIL underflow_flag actual=%0h required=1", in_underflow); end
`endif
        drive(0, '0, 1, 0, '0, 0);
        total++; if (proc_in_data !== 16'h0042) begin bad++; $display("FAIL pushed_head actual=%h required=0042", proc_in_data); end
        total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL pushed_stall actual=%0h required=0", proc_stall); end
        tick();
        $display("txn proc pop 0042");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(0, '0, 0, 1, 16'h0C00 + 16'(i), 0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, '0, 0, 1, 16'($urandom), 1);
            total++; if (out_count !== CW'(2)) begin bad++; $display("FAIL b2b_count actual=%0d required=2", out_count); end
            total++; if (ext_out_data !== exp_out_data) begin bad++; $display("FAIL b2b_data actual=%h required=%h", ext_out_data, exp_out_data); end
            tick();
            $display("txn b2b pop %h push %h", exp_out_data, proc_out_data);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, '0, 0, 0, '0, 1);
            total++; if (ext_out_data !== exp_out_data) begin bad++; $display("FAIL b2b_tail actual=%h required=%h", ext_out_data, exp_out_data); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0));
            total++; if (ext_in_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready n=%0d actual=%0h required=%0h", n, ext_in_ready, exp_ready); end
            total++; if (ext_out_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid n=%0d actual=%0h required=%0h", n, ext_out_valid, exp_valid); end
            total++; if (ext_out_data !== exp_out_data) begin bad++; $display("FAIL rnd_out_data n=%0d actual=%h required=%h", n, ext_out_data, exp_out_data); end
            total++; if (proc_in_data !== exp_in_data) begin bad++; $display("FAIL rnd_in_data n=%0d actual=%h required=%h", n, proc_in_data, exp_in_data); end
            total++; if (proc_stall !== exp_stall) begin bad++; $display("FAIL rnd_stall n=%0d actual=%0h required=%0h", n, proc_stall, exp_stall); end
            total++; if (in_count !== exp_in_count || out_count !== exp_out_count) begin bad++; $display("FAIL rnd_counts n=%0d actual=%0d/%0d required=%0d/%0d", n, in_count, out_count, exp_in_count, exp_out_count); end
`ifdef IO_PORT_ERR_FLAGS_EN
            total++; if (out_overflow !== m_ovf || in_underflow !== m_udf) begin bad++; $display("FAIL rnd_flags n=%0d actual=%0h/%0h required=%0h/%0h", n, out_overflow, in_underflow, m_ovf, m_udf); end
`endif
            $display("txn rnd %0d v=%0d re=%0d we=%0d rdy=%0d in=%0d out=%0d", n, ext_in_valid, proc_in_re, proc_out_we, ext_out_ready, exp_in_count, exp_out_count);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            drive(0, '0, 1, 0, '0, 1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'h0E00 + 16'(i), 0, (i == 0), 16'h0D00, 0);
            tick();
        end
        drive(0, '0, 0, 0, '0, 0);
        total++; if (in_count !== CW'(3) || ext_out_valid !== 1'b1) begin bad++; $display("FAIL pre_rst actual=%0d/%0h required=3/1", in_count, ext_out_valid); end
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        total++; if (in_count !== '0 || out_count !== '0) begin bad++; $display("FAIL mid_rst_counts actual=%0d/%0d required=0/0", in_count, out_count); end
        total++; if (ext_out_valid !== 1'b0 || ext_in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_hs actual=%0h/%0h required=0/0", ext_out_valid, ext_in_ready); end
        $display("txn reset asserted mid-cycle");
        tick();
        reset = 1'b1;
        drive(0, '0, 0, 0, '0, 0);
        tick();
        drive(1, 16'h7777, 0, 0, '0, 0);
        total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready actual=%0h required=1", ext_in_ready); end
        tick();
        $display("txn ext push 7777");
        drive(0, '0, 0, 0, '0, 0);
        total++; if (proc_in_data !== 16'h7777 || in_count !== CW'(1)) begin bad++; $display("FAIL post_rst_head actual=%h/%0d required=7777/1", proc_in_data, in_count); end
    endtask

    initial begin
        test_reset();
        test_in_fifo();
        test_out_overflow();
        test_empty_pop_push();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
